// File: rtl/thread_register_file.sv
// thread_register_file
// Per-thread register file for one ALU/LSU lane: 16 registers of DATA_BITS.
//   R0-R12  general purpose
//   R13     blockIdx  (tracks block_id on every enabled edge)
//   R14     blockDim  (constant THREADS_PER_BLOCK)
//   R15     threadIdx (constant THREAD_ID)
// Operands rs/rt are captured in REQUEST; writeback happens in UPDATE.
// Optional build macro REGFILE_ZERO_R0_EN hardwires R0 to zero.
module thread_register_file #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_REQUEST = 3'b011,
        ST_WAIT    = 3'b100,
        ST_EXECUTE = 3'b101,
        ST_UPDATE  = 3'b110,
        ST_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LSU  = 2'b01,
        SRC_IMM  = 2'b10,
        SRC_NONE = 2'b11
    } wb_src_t;

    // Number of writable registers (R0-R12) and the first one that has storage.
    localparam int NUM_GP = 13;
`ifdef REGFILE_ZERO_R0_EN
    localparam int FIRST_GP = 1;
`else
    localparam int FIRST_GP = 0;
`endif

    localparam logic [3:0]           ADDR_BLOCK_IDX  = 4'd13;
    localparam logic [3:0]           ADDR_BLOCK_DIM  = 4'd14;
    localparam logic [3:0]           ADDR_THREAD_IDX = 4'd15;
    localparam logic [DATA_BITS-1:0] BLOCK_DIM_VAL   = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_IDX_VAL  = DATA_BITS'(THREAD_ID);

    core_state_t state;
    wb_src_t     wb_src;

    logic [DATA_BITS-1:0] gp_regs [FIRST_GP:NUM_GP-1];
    logic [DATA_BITS-1:0] block_idx_q;

    logic                 do_read;
    logic                 do_write;
    logic [DATA_BITS-1:0] wr_data;
    logic [DATA_BITS-1:0] rs_next;
    logic [DATA_BITS-1:0] rt_next;

    assign state  = core_state_t'(core_state);
    assign wb_src = wb_src_t'(decoded_reg_input_mux);

    // Architectural view of any register address, including the read-only ones.
    function automatic logic [DATA_BITS-1:0] read_reg(input logic [3:0] addr);
        logic [DATA_BITS-1:0] value;
        value = '0;
        if (addr == ADDR_BLOCK_IDX) begin
            value = block_idx_q;
        end else if (addr == ADDR_BLOCK_DIM) begin
            value = BLOCK_DIM_VAL;
        end else if (addr == ADDR_THREAD_IDX) begin
            value = THREAD_IDX_VAL;
        end else begin
            // Addresses without storage (R0 when hardwired) fall through as zero.
            for (int i = FIRST_GP; i < NUM_GP; i++) begin
                if (addr == 4'(i)) begin
                    value = gp_regs[i];
                end
            end
        end
        return value;
    endfunction

    // Decode read/write qualifiers and select the writeback source.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        wr_data  = alu_out;
        do_read  = enable && (state == ST_REQUEST);
        do_write = enable && (state == ST_UPDATE) && decoded_reg_write_enable
                   && (decoded_rd_address < ADDR_BLOCK_IDX) && (wb_src != SRC_NONE);
`ifdef REGFILE_ZERO_R0_EN
        if (decoded_rd_address == 4'd0) begin
            do_write = 1'b0;
        end
`endif
        case (wb_src)
            SRC_ALU:  wr_data = alu_out;
            SRC_LSU:  wr_data = lsu_out;
            SRC_IMM:  wr_data = decoded_immediate;
            default:  wr_data = alu_out;
        endcase
        rs_next = read_reg(decoded_rs_address);
        rt_next = read_reg(decoded_rt_address);
    end

    // Capture operands in REQUEST; hold them in every other state.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            rs <= '0;
            rt <= '0;
        end else if (do_read) begin
            rs <= rs_next;
            rt <= rt_next;
        end
    end

    // R13 follows block_id on every enabled edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block_idx_q <= '0;
        end else if (enable) begin
            block_idx_q <= DATA_BITS'(block_id);
        end
    end

    // Writeback into the general-purpose registers during UPDATE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is small and the lane must come out of reset with
            // all registers zero, so every entry is reset explicitly; this keeps
            // it in flops rather than an unresettable RAM macro.
            for (int i = FIRST_GP; i < NUM_GP; i++) begin
                gp_regs[i] <= '0;
            end
        end else if (do_write) begin
            for (int i = FIRST_GP; i < NUM_GP; i++) begin
                if (decoded_rd_address == 4'(i)) begin
                    gp_regs[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_thread_register_file.sv
// Self-checking bench for thread_register_file (THREADS_PER_BLOCK=4, THREAD_ID=2).
// A behavioural model of the 16 architectural registers tracks every clock edge
// and the bench compares rs/rt against it after each edge, plus directed
// literal expectations for the key scenarios.
module tb_thread_register_file;

    localparam int TPB = 4;
    localparam int TID = 2;
`ifdef REGFILE_ZERO_R0_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_UPDATE  = 3'b110;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] decoded_rd_address;
    logic [3:0] decoded_rs_address;
    logic [3:0] decoded_rt_address;
    logic       decoded_reg_write_enable;
    logic [1:0] decoded_reg_input_mux;
    logic [7:0] decoded_immediate;
    logic [7:0] alu_out;
    logic [7:0] lsu_out;
    logic [7:0] rs;
    logic [7:0] rt;

    thread_register_file #(
        .THREADS_PER_BLOCK(TPB),
        .THREAD_ID(TID),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .block_id(block_id),
        .core_state(core_state),
        .decoded_rd_address(decoded_rd_address),
        .decoded_rs_address(decoded_rs_address),
        .decoded_rt_address(decoded_rt_address),
        .decoded_reg_write_enable(decoded_reg_write_enable),
        .decoded_reg_input_mux(decoded_reg_input_mux),
        .decoded_immediate(decoded_immediate),
        .alu_out(alu_out),
        .lsu_out(lsu_out),
        .rs(rs),
        .rt(rt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: writable registers, R13 and the operand outputs.
    logic [7:0] m_gp [16];
    logic [7:0] m_r13;
    logic [7:0] m_rs;
    logic [7:0] m_rt;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a == 13) return m_r13;
        if (a == 14) return 8'(TPB);
        if (a == 15) return 8'(TID);
        if (ZERO_R0 && a == 0) return 8'h00;
        return m_gp[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gp[i] = 8'h00;
        m_r13 = 8'h00;
        m_rs  = 8'h00;
        m_rt  = 8'h00;
    endtask

    // One clock edge: advance the model by the register-file rules, then compare.
    task automatic tick(input string tag);
        logic [7:0] n_rs;
        logic [7:0] n_rt;
        int         rd;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (enable) begin
            n_rs = m_rs;
            n_rt = m_rt;
            if (core_state == S_REQUEST) begin
                n_rs = m_read(int'(decoded_rs_address));
                n_rt = m_read(int'(decoded_rt_address));
            end
            rd = int'(decoded_rd_address);
            if (core_state == S_UPDATE && decoded_reg_write_enable && rd < 13
                && decoded_reg_input_mux != 2'b11 && !(ZERO_R0 && rd == 0)) begin
                case (decoded_reg_input_mux)
                    2'b00:   m_gp[rd] = alu_out;
                    2'b01:   m_gp[rd] = lsu_out;
                    default: m_gp[rd] = decoded_immediate;
                endcase
            end
            m_rs  = n_rs;
            m_rt  = n_rt;
            m_r13 = block_id;
        end
        #1;
        check({tag, ".rs"}, rs, m_rs);
        check({tag, ".rt"}, rt, m_rt);
    endtask

    task automatic drive_idle();
        core_state               = S_IDLE;
        decoded_reg_write_enable = 1'b0;
        decoded_reg_input_mux    = 2'b00;
    endtask

    task automatic do_request(input string tag, input logic [3:0] a, input logic [3:0] b);
        drive_idle();
        core_state         = S_REQUEST;
        decoded_rs_address = a;
        decoded_rt_address = b;
        tick(tag);
        drive_idle();
        core_state = S_WAIT;
        tick({tag, ".wait"});
    endtask

    task automatic do_update(input string tag, input logic [3:0] rd, input logic [1:0] mux,
                             input logic [7:0] alu, input logic [7:0] lsu, input logic [7:0] imm);
        core_state               = S_UPDATE;
        decoded_rd_address       = rd;
        decoded_reg_write_enable = 1'b1;
        decoded_reg_input_mux    = mux;
        alu_out                  = alu;
        lsu_out                  = lsu;
        decoded_immediate        = imm;
        tick(tag);
        drive_idle();
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        enable = 1'b1;
        block_id = 8'h00;
        decoded_rd_address = 4'd0;
        decoded_rs_address = 4'd0;
        decoded_rt_address = 4'd0;
        decoded_immediate = 8'h00;
        alu_out = 8'h00;
        lsu_out = 8'h00;
        drive_idle();

        // Reset state.
        #1;
        check("reset.rs", rs, 8'h00);
        check("reset.rt", rt, 8'h00);
        @(posedge clk);
        #3 reset = 1'b0;

        // Read-only registers and a cleared general register.
        do_request("ro13_14", 4'd13, 4'd14);
        check("r13_after_reset", rs, 8'h00);
        check("r14_blockdim", rt, 8'h04);
        do_request("ro15_r7", 4'd15, 4'd7);
        check("r15_threadidx", rs, 8'h02);
        check("r7_after_reset", rt, 8'h00);

        // Writeback from each source into R5.
        do_update("wr_alu", 4'd5, 2'b00, 8'h3C, 8'h00, 8'h00);
        do_request("rd_alu", 4'd5, 4'd5);
        check("r5_alu", rs, 8'h3C);
        check("r5_alu_same_addr", rt, 8'h3C);
        do_update("wr_lsu", 4'd5, 2'b01, 8'h00, 8'hA5, 8'h00);
        do_request("rd_lsu", 4'd5, 4'd0);
        check("r5_lsu", rs, 8'hA5);
        do_update("wr_imm", 4'd5, 2'b10, 8'h00, 8'h00, 8'h7F);
        do_request("rd_imm", 4'd5, 4'd0);
        check("r5_imm", rs, 8'h7F);

        // Dropped writes: read-only target and reserved source.
        do_update("wr_r14", 4'd14, 2'b10, 8'hFF, 8'hFF, 8'hFF);
        do_update("wr_r3_mux11", 4'd3, 2'b11, 8'hEE, 8'hEE, 8'hEE);
        do_request("rd_r14_r3", 4'd14, 4'd3);
        check("r14_unchanged", rs, 8'h04);
        check("r3_unchanged", rt, 8'h00);

        // Write enable outside UPDATE is ignored.
        core_state = S_WAIT;
        decoded_rd_address = 4'd4;
        decoded_reg_write_enable = 1'b1;
        alu_out = 8'h66;
        tick("we_in_wait");
        drive_idle();
        do_request("rd_r4", 4'd4, 4'd4);
        check("r4_unchanged", rs, 8'h00);

        // enable low: nothing moves, block_id not tracked.
        block_id = 8'h03;
        tick("bid3");
        enable = 1'b0;
        block_id = 8'h09;
        core_state = S_REQUEST;
        decoded_rs_address = 4'd13;
        decoded_rt_address = 4'd14;
        tick("dis_req");
        check("dis_rs_hold", rs, 8'h00);
        do_update("dis_upd", 4'd1, 2'b00, 8'h11, 8'h00, 8'h00);
        enable = 1'b1;
        do_request("en_r1_r13", 4'd1, 4'd13);
        check("r1_unchanged", rs, 8'h00);
        check("r13_stale_value", rt, 8'h03);
        do_request("en_r13", 4'd13, 4'd13);
        check("r13_refreshed", rs, 8'h09);

        // Async reset mid-UPDATE after loading R2.
        do_update("wr_r2", 4'd2, 2'b00, 8'h55, 8'h00, 8'h00);
        do_request("rd_r2", 4'd2, 4'd2);
        check("r2_loaded", rs, 8'h55);
        core_state = S_UPDATE;
        decoded_rd_address = 4'd2;
        decoded_reg_write_enable = 1'b1;
        alu_out = 8'hAA;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_reset.rs", rs, 8'h00);
        check("async_reset.rt", rt, 8'h00);
        #2 reset = 1'b0;
        drive_idle();
        do_request("rd_r2_after_reset", 4'd2, 4'd13);
        check("r2_cleared", rs, 8'h00);

        // R0 behaviour depends on the build option.
        do_update("wr_r0", 4'd0, 2'b00, 8'h99, 8'h00, 8'h00);
        do_request("rd_r0", 4'd0, 4'd0);
        check("r0_value", rs, ZERO_R0 ? 8'h00 : 8'h99);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            enable                   = ($urandom_range(0, 7) != 0);
            block_id                 = 8'($urandom);
            core_state               = 3'($urandom_range(0, 7));
            decoded_rd_address       = 4'($urandom);
            decoded_rs_address       = 4'($urandom);
            decoded_rt_address       = 4'($urandom);
            decoded_reg_write_enable = 1'($urandom);
            decoded_reg_input_mux    = 2'($urandom);
            decoded_immediate        = 8'($urandom);
            alu_out                  = 8'($urandom);
            lsu_out                  = 8'($urandom);
            tick("rand");
        end

        // Final sweep of every register.
        enable = 1'b1;
        for (int a = 0; a < 16; a += 2) begin
            do_request("sweep", 4'(a), 4'(a + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thread_register_file.md
Name: thread_register_file

Overview:
- Per-thread register file; one instance per ALU/LSU thread lane in each core.
- Supplies the rs/rt operands the ALU consumes and accepts the writeback of ALU result, LSU load data or decoded immediate.
- Holds 16 x 8-bit registers:
  - R0-R12 general purpose.
  - R13-R15 read-only: blockIdx, blockDim, threadIdx.
- Sequenced entirely by core_state; no handshake beyond the core state machine.

Parameters:
- THREADS_PER_BLOCK, 4, value reported in R14 (blockDim), 8 bits used.
- THREAD_ID, 0, this lane's index within the block, reported in R15 (threadIdx).
- DATA_BITS, 8, register and operand width.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  lane active; low when block has fewer threads than lanes
- block_id  input  8  current block index, mirrored into R13
- core_state  input  3  core FSM state: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111
- decoded_rd_address  input  4  destination register
- decoded_rs_address  input  4  first source register
- decoded_rt_address  input  4  second source register
- decoded_reg_write_enable  input  1  instruction writes rd
- decoded_reg_input_mux  input  2  writeback source: 00 ALU, 01 LSU, 10 immediate, 11 reserved
- decoded_immediate  input  8  constant for CONST-type writes
- alu_out  input  8  ALU result
- lsu_out  input  8  LSU load data
- rs  output  8  registered operand 1
- rt  output  8  registered operand 2

Behaviour:
- Reset (async, active-high, immediate on assertion regardless of clk):
  - R0-R12 = 0, R13 = 0.
  - R14 = THREADS_PER_BLOCK, R15 = THREAD_ID.
  - rs = 0, rt = 0.
- Reset mid-instruction discards any pending read or write; state after release is exactly the reset state.
- enable low: all registers and outputs hold; no reads, no writes, R13 not refreshed.
- enable high, every rising edge: R13 <= block_id.
- REQUEST (011):
  - rs <= reg[decoded_rs_address], rt <= reg[decoded_rt_address].
  - Values visible one cycle later, in WAIT/EXECUTE.
  - R13 read returns the value held at that edge, i.e. block_id sampled on the previous enabled edge.
- All other states: rs/rt hold their last value.
- UPDATE (110) with decoded_reg_write_enable = 1 and decoded_rd_address < 13:
  - mux 00: reg[rd] <= alu_out.
  - mux 01: reg[rd] <= lsu_out.
  - mux 10: reg[rd] <= decoded_immediate.
  - mux 11: no write.
- Writes to R13-R15 are silently dropped; those registers never change except R13 via block_id.
- Write in any state other than UPDATE: ignored even if decoded_reg_write_enable = 1.
- Read and write never coincide (different states); no bypass required.
- rs_address = rt_address is legal; both outputs get the same value.
- Arithmetic: none; values stored verbatim at 8 bits, no wrap handling needed.

Optional Feature:
- Macro REGFILE_ZERO_R0_EN.
- Defined:
  - R0 is hardwired to 0; writes to R0 are dropped.
  - Reads of R0 always return 0.
  - R0 needs no storage flop.
- Undefined: R0 is an ordinary general-purpose register.

Test Plan:
- Assert reset, then read R13/R14/R15 in REQUEST with block_id=0, THREADS_PER_BLOCK=4, THREAD_ID=2 -> rs/rt = 0, 4, 2 on the next cycle; any R0-R12 read = 0.
- UPDATE with write enable, rd=5, mux=00, alu_out=0x3C; later REQUEST rs=5 -> rs=0x3C. Repeat with mux=01, lsu_out=0xA5 -> 0xA5; mux=10, immediate=0x7F -> 0x7F.
- UPDATE with rd=14, mux=10, immediate=0xFF -> R14 still reads 4. Same write with mux=11 to rd=3 -> R3 unchanged.
- enable=0 across a full REQUEST/UPDATE sequence with alu_out=0x11 to rd=1 -> rs/rt and R1 unchanged; block_id change 3->9 not reflected until enable=1, then R13 reads 9.
- Assert reset asynchronously mid-UPDATE (between edges) after loading R2=0x55 -> rs/rt go to 0 immediately; R2 reads 0 after release.
- With REGFILE_ZERO_R0_EN: UPDATE rd=0, alu_out=0x99, then REQUEST rs=0 -> rs=0. Without the macro: same sequence -> rs=0x99.
